// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator: one val/rdy request becomes one full-duplex, MSB-first transfer whose MISO word is returned as a response.
// Optional recv_parity output is enabled by defining SPI_MASTER_PARITY_EN.
module spi_master_ctrl #(
  parameter int unsigned NBITS   = 34,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] send_msg,
  input  logic             send_val,
  output logic             send_rdy,
  output logic [NBITS-1:0] recv_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
`ifdef SPI_MASTER_PARITY_EN
  output logic             recv_parity,
`endif
  output logic             spi_cs,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int unsigned DW = $clog2(CLK_DIV + 1);
  localparam int unsigned BW = $clog2(NBITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t           state, state_next;
  logic [DW-1:0]    div_cnt, div_next;
  logic [BW-1:0]    bit_cnt, bit_next;
  logic             phase, phase_next;
  logic [NBITS-1:0] sreg, sreg_next;
  logic             miso_q, miso_next;
  logic             div_wrap;

  logic             cs_d, sclk_d, mosi_d, send_rdy_d, recv_val_d;
  logic [NBITS-1:0] recv_msg_d;
`ifdef SPI_MASTER_PARITY_EN
  logic             parity_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      phase    <= 1'b0;
      sreg     <= '0;
      miso_q   <= 1'b0;
      send_rdy <= 1'b0;
      recv_val <= 1'b0;
      recv_msg <= '0;
      spi_cs   <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
`ifdef SPI_MASTER_PARITY_EN
      recv_parity <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      div_cnt  <= div_next;
      bit_cnt  <= bit_next;
      phase    <= phase_next;
      sreg     <= sreg_next;
      miso_q   <= miso_next;
      send_rdy <= send_rdy_d;
      recv_val <= recv_val_d;
      recv_msg <= recv_msg_d;
      spi_cs   <= cs_d;
      spi_sclk <= sclk_d;
      spi_mosi <= mosi_d;
`ifdef SPI_MASTER_PARITY_EN
      recv_parity <= parity_d;
`endif
    end
  end

  // phase=1 is the SCLK-high half of a bit period; the registered SCLK edge
  // follows the first cycle of each half, which is where MISO is sampled / the word shifts.
  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    phase_next = phase;
    sreg_next  = sreg;
    miso_next  = miso_q;
    div_wrap   = (div_cnt == DIV_LAST);
    case (state)
      IDLE: begin
        if (send_val && send_rdy) begin
          sreg_next  = send_msg;
          div_next   = '0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        div_next = div_wrap ? '0 : div_cnt + DW'(1);
        if (div_wrap) begin
          phase_next = 1'b1;
          bit_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        div_next = div_wrap ? '0 : div_cnt + DW'(1);
        if (phase && div_cnt == '0)
          miso_next = spi_miso;
        if (!phase && div_cnt == '0)
          sreg_next = {sreg[NBITS-2:0], miso_q};
        if (div_wrap) begin
          phase_next = !phase;
          if (!phase) begin
            if (bit_cnt == BIT_LAST) state_next = HOLD;
            else                     bit_next   = bit_cnt + BW'(1);
          end
        end
      end
      HOLD: begin
        div_next = div_wrap ? '0 : div_cnt + DW'(1);
        if (div_wrap) state_next = DONE;
      end
      DONE: begin
        if (recv_val && recv_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // MOSI drops low with the final SCLK fall so received bits never appear on it.
  always_comb begin
    cs_d       = 1'b1;
    sclk_d     = 1'b0;
    mosi_d     = 1'b0;
    send_rdy_d = (state_next == IDLE);
    recv_val_d = (state == DONE) && !(recv_val && recv_rdy);
    recv_msg_d = (state == DONE) ? sreg : recv_msg;
    case (state)
      SETUP: begin
        cs_d   = 1'b0;
        mosi_d = sreg_next[NBITS-1];
      end
      SHIFT: begin
        cs_d   = 1'b0;
        sclk_d = phase;
        if (phase || bit_cnt != BIT_LAST) mosi_d = sreg_next[NBITS-1];
      end
      HOLD:    cs_d = 1'b0;
      default: ;
    endcase
  end

`ifdef SPI_MASTER_PARITY_EN
  always_comb begin
    parity_d = recv_parity;
    if (state == HOLD && state_next == DONE) parity_d = ^sreg;
  end
`endif

endmodule
